// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns and code constants for the 7-segment path
package seg7_pkg;

    localparam int SEG_W  = 7;
    localparam int CODE_W = 4;

    // Segment ordering {a,b,c,d,e,f,g}, active-high; identical to the encoder side.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1110011;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;
    localparam logic [CODE_W-1:0] CODE_INV   = 4'hE;

endpackage

// File: rtl/seg7_to_code.sv
// rtl/seg7_to_code.sv - combinational segment-pattern to BCD code decoder
module seg7_to_code
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]  seg,
    output logic [CODE_W-1:0] code
);

    // Exact-match lookup; anything not a digit or blank is reported as invalid.
    always_comb begin
        code = CODE_INV;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_INV;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers per-digit codes from a multiplexed segment bus
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 3,
    parameter int CNT_W  = 3
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample,
    input  logic [NDIG-1:0]        dig_sel,
    input  logic [SEG_W-1:0]       seg_in,
    output logic [CODE_W*NDIG-1:0] code_out,
    output logic [NDIG-1:0]        upd,
    output logic                   frame_done,
    output logic                   sel_err
);

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] cand     [NDIG];
    logic [CNT_W-1:0]  cnt      [NDIG];
    logic [CNT_W-1:0]  cnt_nxt  [NDIG];
    logic [NDIG-1:0]   hit;
    logic [NDIG-1:0]   match;
    logic [NDIG-1:0]   commit;
    logic [NDIG-1:0]   seen;
    logic [NDIG-1:0]   seen_nxt;
    logic              sel_ok;

    seg7_to_code u_dec (
        .seg  (seg_in),
        .code (code)
    );

    // Per-digit stability counting and commit decision for the current sample.
    always_comb begin
        sel_ok   = $onehot(dig_sel);
        seen_nxt = seen;
        if (sample && sel_ok) begin
            seen_nxt = seen | dig_sel;
        end
        for (int i = 0; i < NDIG; i++) begin
            hit[i]   = sample && sel_ok && dig_sel[i];
            match[i] = (code == cand[i]);
            if (match[i]) begin
                cnt_nxt[i] = (cnt[i] == STABLE_C) ? cnt[i] : cnt[i] + ONE_C;
            end else begin
                cnt_nxt[i] = ONE_C;
            end
            // A fresh candidate commits at once only when one sample is enough;
            // a saturated matching candidate never re-commits.
            commit[i] = hit[i] && (cnt_nxt[i] == STABLE_C) &&
                        (!match[i] || (cnt[i] != STABLE_C));
        end
    end

    // Candidate, counter, committed code and per-digit update pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                cand[i]                    <= CODE_BLANK;
                cnt[i]                     <= '0;
                code_out[CODE_W*i +: CODE_W] <= CODE_BLANK;
            end
            upd <= '0;
        end else begin
            upd <= '0;
            for (int i = 0; i < NDIG; i++) begin
                if (hit[i]) begin
                    cand[i] <= code;
                    cnt[i]  <= cnt_nxt[i];
                end
                if (commit[i] && (code_out[CODE_W*i +: CODE_W] != code)) begin
                    code_out[CODE_W*i +: CODE_W] <= code;
                    upd[i]                       <= 1'b1;
                end
            end
        end
    end

    // Frame coverage tracking plus the frame and select-error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen       <= '0;
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sel_err    <= sample && !sel_ok;
            if (&seen_nxt) begin
                seen       <= '0;
                frame_done <= 1'b1;
            end else begin
                seen <= seen_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        sample;
    logic [3:0]  dig_sel;
    logic [6:0]  seg_in;
    logic [15:0] code_out;
    logic [3:0]  upd;
    logic        frame_done;
    logic        sel_err;

    int n_cmp;
    int n_bad;

    seg7_scan_decoder #(.NDIG(4), .STABLE(3), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample     (sample),
        .dig_sel    (dig_sel),
        .seg_in     (seg_in),
        .code_out   (code_out),
        .upd        (upd),
        .frame_done (frame_done),
        .sel_err    (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic put(input logic [3:0] sel, input logic [6:0] seg);
        @(negedge clk);
        sample  = 1'b1;
        dig_sel = sel;
        seg_in  = seg;
        @(posedge clk);
        #1;
        sample = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sample = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        sample = 0; dig_sel = 0; seg_in = 0; rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1;
        idle(5);
        n_cmp++; if (code_out !== 16'hFFFF) begin n_bad++; $display("FAIL reset_code got %h want FFFF", code_out); end
        n_cmp++; if (upd !== 4'b0) begin n_bad++; $display("FAIL reset_upd got %b want 0000", upd); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame got %b want 0", frame_done); end
        n_cmp++; if (sel_err !== 1'b0) begin n_bad++; $display("FAIL reset_selerr got %b want 0", sel_err); end
    endtask

    task automatic test_commit();
        put(4'b0001, 7'b1111001);
        put(4'b0001, 7'b1111001);
        n_cmp++; if (code_out !== 16'hFFFF || upd !== 4'b0) begin n_bad++; $display("FAIL commit_early got %h/%b want FFFF/0000", code_out, upd); end
        put(4'b0001, 7'b1111001);
        n_cmp++; if (code_out !== 16'hFFF3) begin n_bad++; $display("FAIL commit_code got %h want FFF3", code_out); end
        n_cmp++; if (upd !== 4'b0001) begin n_bad++; $display("FAIL commit_upd got %b want 0001", upd); end
        put(4'b0001, 7'b1111001);
        n_cmp++; if (upd !== 4'b0 || code_out !== 16'hFFF3) begin n_bad++; $display("FAIL commit_sat got %b/%h want 0000/FFF3", upd, code_out); end
    endtask

    task automatic test_glitch();
        put(4'b0100, 7'b1011011);
        put(4'b0100, 7'b1011011);
        put(4'b0100, 7'b1011011);
        n_cmp++; if (code_out !== 16'hF5F3 || upd !== 4'b0100) begin n_bad++; $display("FAIL glitch_hold5 got %h/%b want F5F3/0100", code_out, upd); end
        put(4'b0100, 7'b1011011);
        put(4'b0100, 7'b0110000);
        n_cmp++; if (code_out !== 16'hF5F3 || upd !== 4'b0) begin n_bad++; $display("FAIL glitch_one got %h/%b want F5F3/0000", code_out, upd); end
        put(4'b0100, 7'b1011011);
        put(4'b0100, 7'b1011011);
        n_cmp++; if (code_out !== 16'hF5F3 || upd !== 4'b0) begin n_bad++; $display("FAIL glitch_recount got %h/%b want F5F3/0000", code_out, upd); end
        put(4'b0100, 7'b1011011);
        n_cmp++; if (code_out !== 16'hF5F3 || upd !== 4'b0) begin n_bad++; $display("FAIL glitch_same got %h/%b want F5F3/0000", code_out, upd); end
    endtask

    task automatic test_frame();
        for (int scan = 0; scan < 2; scan++) begin
            for (int d = 0; d < 4; d++) begin
                put(4'b0001 << d, 7'b0000000);
                n_cmp++;
                if (frame_done !== (d == 3)) begin
                    n_bad++;
                    $display("FAIL frame_s%0d_d%0d got %b want %b", scan, d, frame_done, (d == 3));
                end
            end
            idle(1);
            n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_pulse_s%0d got %b want 0", scan, frame_done); end
        end
        n_cmp++; if (code_out !== 16'hF5F3) begin n_bad++; $display("FAIL frame_code got %h want F5F3", code_out); end
    endtask

    task automatic test_sel_err();
        put(4'b0110, 7'b1111111);
        n_cmp++; if (sel_err !== 1'b1) begin n_bad++; $display("FAIL selerr_multi got %b want 1", sel_err); end
        put(4'b0000, 7'b1111111);
        n_cmp++; if (sel_err !== 1'b1) begin n_bad++; $display("FAIL selerr_zero got %b want 1", sel_err); end
        n_cmp++; if (code_out !== 16'hF5F3 || upd !== 4'b0) begin n_bad++; $display("FAIL selerr_state got %h/%b want F5F3/0000", code_out, upd); end
        idle(1);
        n_cmp++; if (sel_err !== 1'b0) begin n_bad++; $display("FAIL selerr_pulse got %b want 0", sel_err); end
        // Blank candidates of digits 0 and 2 are two samples in, so one more commits them.
        put(4'b0001, 7'b0000000);
        n_cmp++; if (code_out !== 16'hF5FF || upd !== 4'b0001) begin n_bad++; $display("FAIL selerr_d0 got %h/%b want F5FF/0001", code_out, upd); end
        put(4'b1000, 7'b0000000);
        n_cmp++; if (frame_done !== 1'b0 || upd !== 4'b0) begin n_bad++; $display("FAIL selerr_noframe got %b/%b want 0/0000", frame_done, upd); end
        put(4'b0010, 7'b0000000);
        put(4'b0100, 7'b0000000);
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL selerr_frame got %b want 1", frame_done); end
        n_cmp++; if (code_out !== 16'hFFFF || upd !== 4'b0100) begin n_bad++; $display("FAIL selerr_d2 got %h/%b want FFFF/0100", code_out, upd); end
    endtask

    task automatic test_invalid_reset();
        put(4'b0010, 7'b1010101);
        put(4'b0010, 7'b1010101);
        put(4'b0010, 7'b1010101);
        n_cmp++; if (code_out !== 16'hFFEF || upd !== 4'b0010) begin n_bad++; $display("FAIL inv_commit got %h/%b want FFEF/0010", code_out, upd); end
        put(4'b0010, 7'b0110000);
        put(4'b0010, 7'b0110000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (code_out !== 16'hFFFF || upd !== 4'b0) begin n_bad++; $display("FAIL async_reset got %h/%b want FFFF/0000", code_out, upd); end
        @(negedge clk); rst_n = 1'b1;
        put(4'b0010, 7'b0110000);
        put(4'b0010, 7'b0110000);
        n_cmp++; if (code_out !== 16'hFFFF || upd !== 4'b0) begin n_bad++; $display("FAIL reset_discard got %h/%b want FFFF/0000", code_out, upd); end
        put(4'b0010, 7'b0110000);
        n_cmp++; if (code_out !== 16'hFF1F || upd !== 4'b0010) begin n_bad++; $display("FAIL post_reset_commit got %h/%b want FF1F/0010", code_out, upd); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_commit();
        test_glitch();
        test_frame();
        test_sel_err();
        test_invalid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
